vga_scanout: RTL
================

// Module: vga_scanout
// PURPOSE
//  Display-side consumer of the stage renderers' (x,y)->RGB332 interface.
//  Generates 640x480@60 VGA timing and pixel-clock enable; drives 80x60 logical coords (8x upscale).
//  Samples the renderer's combinational colour and registers it to the DAC pins, aligned with hsync/vsync.
//  Sits between any bomb_stage_* renderer (or its mux) and the board VGA connector.
// PARAMETERS
//  CLK_DIV      2    clk cycles per pixel tick (1 = tick every cycle); 50 MHz/2 = 25 MHz
//  H_ACTIVE     640  visible pixels per line
//  H_FP         16   horizontal front porch, ticks
//  H_SYNC       96   hsync width, ticks
//  H_BP         48   horizontal back porch, ticks
//  V_ACTIVE     480  visible lines
//  V_FP         10   vertical front porch, lines
//  V_SYNC       2    vsync width, lines
//  V_BP         33   vertical back porch, lines
//  SCALE_SHIFT  3    log2 of upscale factor; pix_x = h>>SCALE_SHIFT
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  pix_x        out  7   logical column 0..79 to renderer
//  pix_y        out  7   logical row 0..59 to renderer
//  pix_red      in   3   renderer red, combinational in pix_x/pix_y
//  pix_green    in   3   renderer green
//  pix_blue     in   2   renderer blue
//  vga_r        out  3   DAC red
//  vga_g        out  3   DAC green
//  vga_b        out  2   DAC blue
//  vga_hs       out  1   hsync, active low
//  vga_vs       out  1   vsync, active low
//  frame_start  out  1   1-clk pulse when pixel (0,0) loads to pins
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): div, h, v counters = 0.
//    Reset outputs: vga_r/g/b=0, vga_hs=vga_vs=1, frame_start=0, pix_x=pix_y=0.
//    Reset mid-frame aborts the frame; no partial sync pulse is stretched.
//  - Tick: div counts 0..CLK_DIV-1 each clk; tick=1 in cycle where div==CLK_DIV-1.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Counters 10 bit; H_TOTAL, V_TOTAL <= 1024.
//  - On tick: h wraps at H_TOTAL-1 to 0 (carry); v advances on carry, wraps at V_TOTAL-1.
//  - active = (h<H_ACTIVE)&&(v<V_ACTIVE). pix_x = active ? h>>SCALE_SHIFT : 0; same for pix_y/v.
//    pix_x/pix_y decode combinationally from the counter registers (glitch-free within a tick).
//  - Output regs load only on tick, from current (pre-increment) h/v:
//    - vga_r/g/b = active ? pix_* : 0
//    - vga_hs = !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1])
//    - vga_vs = !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1])
//    Latency counter->pins = 1 tick; colour and sync always aligned.
//  - frame_start=1 for exactly one clk, on the tick loading h=0,v=0; else 0.
//    First tick after reset release therefore pulses frame_start.
//  - Outputs hold between ticks. Renderer inputs are sampled only on tick; never X-propagated in blanking.
// STRUCTURE
//  - vga_pkg: timing default localparams; typedef struct packed {logic[2:0] r; logic[2:0] g; logic[1:0] b;} rgb332_t.
//  - Sub-module vga_axis_counter (TOTAL, ACTIVE, SYNC_START, SYNC_LEN):
//    inc/clr in; count, active, sync_n, wrap out. Instantiated twice (h with inc=tick, v with inc=tick&h_wrap).
//  - Top: divider, coordinate decode, output register stage.
// TESTING
//  1. rst_n=0 for 10 clk -> vga_hs=vga_vs=1, vga_r/g/b=0, pix_x=pix_y=0, frame_start=0.
//  2. Release reset, CLK_DIV=2 -> first vga_hs fall at tick 657 (clk 1314); low exactly 96 ticks; period 800 ticks.
//  3. Free run -> vga_vs low exactly 1600 ticks; frame_start period 420000 ticks (840000 clk), width 1 clk.
//  4. Tie pix_red=5, pix_green=7, pix_blue=1:
//     - pins 5/7/1 for h<640,v<480
//     - 0/0/0 for h in 640..799 and for v in 480..524
//  5. Coord decode: h=7->pix_x=0; h=8..15->1; h=639->79; v=479->pix_y=59; h=640 or v=480->pix_x=pix_y=0.
//  6. Pulse rst_n=0 one clk at h=300,v=200 -> counters 0 next clk, hs=vs=1; frame_start on first tick after release.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// vga_scanout shared types and default 640x480@60 timing.
// Imported by the axis counter, the scanout top and the bench.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 3;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Renderer-facing coordinate/colour bus plus the VGA connector pins.
// master = scanout side, slave = renderer / connector side.
interface vga_scanout_if;

    logic [6:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_red;
    logic [2:0] pix_green;
    logic [1:0] pix_blue;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       frame_start;

    modport master (
        output pix_x, pix_y,
        input  pix_red, pix_green, pix_blue,
        output vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, frame_start
    );

    modport slave (
        input  pix_x, pix_y,
        output pix_red, pix_green, pix_blue,
        input  vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, frame_start
    );

endinterface

// File: rtl/vga_scanout_axis_counter.sv
// One timing axis: wrapping position counter with active/sync decode.
// Used once per line (h) and once per frame (v).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             sync_n,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN - 1);

    assign wrap   = (count == LAST);
    assign active = (count < ACT_END);
    assign sync_n = !((count >= SYNC_LO) && (count <= SYNC_HI));

    // Position advances on inc and folds back to 0 after the last slot.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pixel-tick divider, h/v timing, 8x coord decode and
// a registered colour/sync stage so DAC and sync pins stay aligned.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             clr;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_act, v_act, active;
    logic             h_sync_n, v_sync_n;
    logic             h_wrap, v_wrap;
    logic             at_origin;
    logic             hs_q, vs_q, fs_q;
    rgb332_t          pix;
    rgb332_t          rgb_q;

    assign tick = (div == DIV_W'(CLK_DIV - 1));
    assign clr  = !rst_n;

    // Pixel-clock enable: one tick every CLK_DIV clk cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else
            div <= tick ? '0 : div + DIV_W'(1);
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h (
        .clk    (clk),
        .clr    (clr),
        .inc    (tick),
        .count  (h),
        .active (h_act),
        .sync_n (h_sync_n),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v (
        .clk    (clk),
        .clr    (clr),
        .inc    (tick && h_wrap),
        .count  (v),
        .active (v_act),
        .sync_n (v_sync_n),
        .wrap   (v_wrap)
    );

    assign active    = h_act && v_act;
    assign bus.pix_x = active ? 7'(h >> SCALE_SHIFT) : '0;
    assign bus.pix_y = active ? 7'(v >> SCALE_SHIFT) : '0;

    assign pix.r = bus.pix_red;
    assign pix.g = bus.pix_green;
    assign pix.b = bus.pix_blue;

    // Tracks h==0,v==0 from the wrap carries so frame_start needs no compare.
    always_ff @(posedge clk) begin
        if (!rst_n)
            at_origin <= 1'b1;
        else if (tick)
            at_origin <= h_wrap && v_wrap;
    end

    // Pin stage: loads on tick from pre-increment h/v; blanking forces black.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= tick && at_origin;
            if (tick) begin
                rgb_q <= active ? pix : '0;
                hs_q  <= h_sync_n;
                vs_q  <= v_sync_n;
            end
        end
    end

    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = fs_q;

endmodule
